// File: rtl/flash_reader.sv
// flash_reader: reads a burst of words from a 16-bit asynchronous NOR flash,
// holds the address and OE for a programmable access wait, and hands the
// words downstream over a valid/ready stream through a 2-entry prefetch FIFO.
// Optional build macro: FLASH_READER_BYTESWAP_EN (store each word byte-swapped).
module flash_reader #(
    parameter int unsigned WAIT_CYCLES = 3,
    parameter int unsigned ADDR_W      = 22,
    parameter int unsigned DATA_W      = 16
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    input  logic [ADDR_W-1:0] start_addr,
    input  logic [ADDR_W-1:0] word_count,
    output logic              busy,
    output logic              done,
    input  logic [DATA_W-1:0] flash_d,
    output logic [ADDR_W-1:0] flash_addr,
    output logic              flash_cs,
    output logic              flash_oe,
    output logic [DATA_W-1:0] word_data,
    output logic              word_valid,
    input  logic              word_ready
);

    localparam int unsigned WAIT_W  = 4;
    localparam int unsigned COUNT_W = 2;
    localparam int unsigned HALF_W  = DATA_W / 2;

    typedef enum logic [2:0] {
        IDLE,
        ISSUE,
        WAIT,
        SAMPLE,
        HOLD,
        FINISH
    } state_t;

    state_t              state_q, state_d;
    logic [ADDR_W-1:0]   remaining_q, remaining_d;
    logic [WAIT_W-1:0]   wait_cnt_q, wait_cnt_d;
    logic [ADDR_W-1:0]   addr_d;
    logic                busy_d, done_d, cs_d, oe_d;
    logic [COUNT_W-1:0]  count_q;
    logic [DATA_W-1:0]   tail_q;
    logic                push_c;
    logic                pop_c;
    logic [DATA_W-1:0]   push_data_c;

    // Word as stored in the FIFO
`ifdef FLASH_READER_BYTESWAP_EN
    assign push_data_c = {flash_d[HALF_W-1:0], flash_d[DATA_W-1:HALF_W]};
`else
    assign push_data_c = flash_d;
`endif

    assign pop_c = word_valid && word_ready;

    // State, control outputs and burst bookkeeping registers
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= IDLE;
            remaining_q <= '0;
            wait_cnt_q  <= '0;
            flash_addr  <= '0;
            busy        <= 1'b0;
            done        <= 1'b0;
            flash_cs    <= 1'b1;
            flash_oe    <= 1'b1;
        end else begin
            state_q     <= state_d;
            remaining_q <= remaining_d;
            wait_cnt_q  <= wait_cnt_d;
            flash_addr  <= addr_d;
            busy        <= busy_d;
            done        <= done_d;
            flash_cs    <= cs_d;
            flash_oe    <= oe_d;
        end
    end

    // Next-state and next-output decode for the access sequencer
    always_comb begin
        state_d     = state_q;
        remaining_d = remaining_q;
        wait_cnt_d  = wait_cnt_q;
        addr_d      = flash_addr;
        busy_d      = busy;
        done_d      = 1'b0;
        cs_d        = flash_cs;
        oe_d        = flash_oe;
        push_c      = 1'b0;

        case (state_q)
            IDLE: begin
                cs_d = 1'b1;
                oe_d = 1'b1;
                // A start coinciding with the done pulse is not accepted
                if (start && !done) begin
                    addr_d      = start_addr;
                    remaining_d = word_count;
                    busy_d      = 1'b1;
                    if (word_count == '0) begin
                        state_d = FINISH;
                    end else begin
                        state_d = ISSUE;
                    end
                end
            end

            ISSUE, HOLD: begin
                if (count_q < COUNT_W'(2)) begin
                    cs_d = 1'b0;
                    oe_d = 1'b0;
                    // OE is low through WAIT and SAMPLE; the sample edge ends SAMPLE
                    if (WAIT_CYCLES <= 1) begin
                        state_d = SAMPLE;
                    end else begin
                        wait_cnt_d = WAIT_W'(WAIT_CYCLES - 1);
                        state_d    = WAIT;
                    end
                end else begin
                    cs_d    = 1'b1;
                    oe_d    = 1'b1;
                    state_d = HOLD;
                end
            end

            WAIT: begin
                wait_cnt_d = wait_cnt_q - WAIT_W'(1);
                if (wait_cnt_q <= WAIT_W'(1)) begin
                    state_d = SAMPLE;
                end
            end

            SAMPLE: begin
                push_c      = 1'b1;
                addr_d      = flash_addr + ADDR_W'(1);
                remaining_d = remaining_q - ADDR_W'(1);
                if (remaining_q == ADDR_W'(1)) begin
                    cs_d    = 1'b1;
                    oe_d    = 1'b1;
                    state_d = FINISH;
                end else begin
                    state_d = ISSUE;
                end
            end

            FINISH: begin
                cs_d = 1'b1;
                oe_d = 1'b1;
                if (count_q == '0) begin
                    done_d  = 1'b1;
                    busy_d  = 1'b0;
                    state_d = IDLE;
                end
            end

            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // Two-entry prefetch FIFO: word_data is the head register, tail_q the second slot
    always_ff @(posedge clk) begin
        if (reset) begin
            count_q    <= '0;
            tail_q     <= '0;
            word_data  <= '0;
            word_valid <= 1'b0;
        end else begin
            case ({push_c, pop_c})
                2'b10: begin
                    if (count_q == '0) begin
                        word_data <= push_data_c;
                    end else begin
                        tail_q <= push_data_c;
                    end
                    count_q    <= count_q + COUNT_W'(1);
                    word_valid <= 1'b1;
                end
                2'b01: begin
                    if (count_q == COUNT_W'(2)) begin
                        word_data <= tail_q;
                    end
                    count_q    <= count_q - COUNT_W'(1);
                    word_valid <= (count_q == COUNT_W'(2));
                end
                2'b11: begin
                    // Push only happens with one entry buffered, so the new word becomes head
                    word_data <= push_data_c;
                end
                default: begin
                end
            endcase
        end
    end

endmodule

// File: doc/flash_reader.md
Name: flash_reader

Overview:
- Upstream stage for the SelectMAP loader.
- Sequences asynchronous reads from the 16-bit parallel NOR flash with a programmable access wait. Delivers words over a valid/ready stream through a 2-entry prefetch FIFO.
- Lets the loader, or any later consumer, pull bitstream words without knowing the flash access timing.
- Lives in the MAX II CPLD, between the flash pins and the configuration engine.

Parameters:
- WAIT_CYCLES, 3, clk cycles between address/OE asserted and flash_d sampled (1..15).
- ADDR_W, 22, flash word-address width.
- DATA_W, 16, flash data width.

Ports:
- clk  in  1  system clock
- reset  in  1  synchronous reset, active high
- start  in  1  one-cycle pulse; launches a burst (ignored while busy)
- start_addr  in  ADDR_W  first word address, latched on start
- word_count  in  ADDR_W  number of words to read, latched on start
- busy  out  1  high from the cycle after start until the done pulse
- done  out  1  one-cycle pulse when the burst completes
- flash_d  in  DATA_W  flash data bus
- flash_addr  out  ADDR_W  flash word address
- flash_cs  out  1  flash chip select, active low
- flash_oe  out  1  flash output enable, active low
- word_data  out  DATA_W  FIFO head word
- word_valid  out  1  FIFO non-empty
- word_ready  in  1  consumer accepts word_data this cycle

Behaviour:
- Reset values:
  - busy=0, done=0, flash_cs=1, flash_oe=1, flash_addr=0.
  - word_valid=0, word_data=0.
  - FIFO count=0, remaining=0, state=IDLE.
- Reset mid-burst: same values on the next edge; FIFO flushed; no done pulse.
- FSM states: IDLE, ISSUE, WAIT, SAMPLE, HOLD, FINISH.
- IDLE:
  - flash_cs=1, flash_oe=1.
  - On start: latch flash_addr<=start_addr and remaining<=word_count; busy<=1.
  - If word_count==0, go to FINISH; otherwise go to ISSUE.
- ISSUE:
  - If FIFO count<2, assert flash_cs=0 and flash_oe=0, load wait counter with WAIT_CYCLES-1, go to WAIT.
  - Else go to HOLD with cs/oe deasserted.
- HOLD: stay until count<2, then behave as ISSUE.
- WAIT: cs/oe stay low and flash_addr is stable; decrement the counter; at 0 go to SAMPLE.
- SAMPLE:
  - Push flash_d into the FIFO.
  - flash_addr<=flash_addr+1, modulo 2^ADDR_W (0x3FFFFF wraps to 0x000000).
  - remaining<=remaining-1.
  - If the new remaining==0: deassert cs/oe and go to FINISH. Else go to ISSUE; cs/oe stay low.
- Access latency: first word visible on word_valid WAIT_CYCLES+2 cycles after start (start→ISSUE, ISSUE, WAIT×WAIT_CYCLES, SAMPLE push).
- FINISH: wait for FIFO empty (count==0), then done=1 for exactly one cycle, busy<=0, go to IDLE.
- FIFO behaviour:
  - word_valid=(count!=0); word_data is the head entry, registered.
  - Pop when word_valid&&word_ready.
  - Push and pop in the same cycle: count unchanged, order preserved.
  - Overflow is impossible: an access is only issued with count<2, and only one access is in flight.
  - A pop with count==0 is a no-op.
- start while busy is ignored; latched start_addr/word_count are unaffected.
- start on the same cycle as done is ignored; a new start is accepted the cycle after done.
- done and word_valid are never high together.

Optional Feature:
- Macro FLASH_READER_BYTESWAP_EN.
- Defined: each word is stored as {flash_d[7:0], flash_d[15:8]}, for bitstream images written low-byte-first.
- Undefined: flash_d is stored unmodified.
- Latency, handshake and FSM are identical in both builds.

Test Plan:
- WAIT_CYCLES=3; start, start_addr=0x010000, word_count=4; word_ready=1; flash model returns addr[15:0] → words 0x0000,0x0001,0x0002,0x0003 in order, first word_valid 5 cycles after start. Then flash_addr=0x010004, one done pulse, busy low.
- Same burst with word_ready=0 for 20 cycles → word_valid after 5 cycles; state parks in HOLD with flash_cs=1 once 2 words are buffered. After ready=1, all 4 words arrive in order, no loss or duplication.
- start_addr=0x3FFFFE, word_count=3 → addresses sampled 0x3FFFFE, 0x3FFFFF, 0x000000; done after the last pop.
- word_count=0 → no flash_cs assertion; done pulses 2 cycles after start; word_valid stays 0.
- reset asserted during WAIT of word 2 of 8 → next cycle flash_cs=1, flash_oe=1, word_valid=0, busy=0, no done; a following start with word_count=1 runs cleanly.
- Build with FLASH_READER_BYTESWAP_EN, flash returns 0x12AB → word_data=0xAB12; a second start pulse mid-burst is ignored (word count and addresses unchanged).
